// File: rtl/fpu_cmp_minmax.sv
// Two-stage FEQ/FLT/FLE/FMIN/FMAX unit for single precision with RISC-V NaN and signed-zero rules.
// S1 captures operands and class vectors; S2 registers result, nv and out_valid.
module fpu_cmp_minmax #(
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [9:0]  cls1,
    input  logic [9:0]  cls2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        nv,
    output logic        nv_acc,
    input  logic        nv_clr
);

    localparam logic [2:0] OpFeq  = 3'd0;
    localparam logic [2:0] OpFlt  = 3'd1;
    localparam logic [2:0] OpFle  = 3'd2;
    localparam logic [2:0] OpFmin = 3'd3;
    localparam logic [2:0] OpFmax = 3'd4;

    logic        s1_valid;
    logic [2:0]  s1_op;
    logic [31:0] s1_a, s1_b;
    logic [9:0]  s1_cls1, s1_cls2;

    logic advance, accept;
    assign advance  = ~out_valid | out_ready;
    assign in_ready = ~s1_valid | advance;
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= 3'd0;
            s1_a     <= 32'd0;
            s1_b     <= 32'd0;
            s1_cls1  <= 10'd0;
            s1_cls2  <= 10'd0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_op    <= op;
                s1_a     <= rs1;
                s1_b     <= rs2;
                s1_cls1  <= cls1;
                s1_cls2  <= cls2;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    logic nan1, nan2, snan1, snan2, zero1, zero2;
    logic any_nan, any_snan, both_zero;
    logic sa, sb, mag_lt, mag_eq, mag_gt, same;
    logic a_lt_b, b_lt_a;
    logic [31:0] res_d;
    logic        nv_d;

    assign nan1      = s1_cls1[8] | s1_cls1[9];
    assign nan2      = s1_cls2[8] | s1_cls2[9];
    assign snan1     = s1_cls1[8];
    assign snan2     = s1_cls2[8];
    assign zero1     = s1_cls1[3] | s1_cls1[4];
    assign zero2     = s1_cls2[3] | s1_cls2[4];
    assign any_nan   = nan1 | nan2;
    assign any_snan  = snan1 | snan2;
    assign both_zero = zero1 & zero2;

    assign sa     = s1_a[31];
    assign sb     = s1_b[31];
    assign mag_lt = s1_a[30:0] < s1_b[30:0];
    assign mag_eq = s1_a[30:0] == s1_b[30:0];
    assign mag_gt = ~mag_lt & ~mag_eq;
    assign same   = (sa == sb) & mag_eq;

    // Strict total order with -0 < +0; compare ops mask the zero case separately.
    assign a_lt_b = (sa != sb) ? sa : (sa ? mag_gt : mag_lt);
    assign b_lt_a = (sa != sb) ? sb : (sa ? mag_lt : mag_gt);

    logic unused_cls;
    assign unused_cls = ^{s1_cls1[7:5], s1_cls1[2:0], s1_cls2[7:5], s1_cls2[2:0]};

    always_comb begin
        res_d = 32'd0;
        nv_d  = 1'b0;
        case (s1_op)
            OpFeq: begin
                res_d = {31'd0, ~any_nan & (both_zero | same)};
                nv_d  = any_snan;
            end
            OpFlt: begin
                res_d = {31'd0, ~any_nan & ~both_zero & a_lt_b};
                nv_d  = any_nan;
            end
            OpFle: begin
                res_d = {31'd0, ~any_nan & (both_zero | same | a_lt_b)};
                nv_d  = any_nan;
            end
            OpFmin, OpFmax: begin
                nv_d = any_snan;
                if (nan1 & nan2) begin
                    res_d = CANON_NAN;
                end else if (nan1) begin
                    res_d = s1_b;
                end else if (nan2) begin
                    res_d = s1_a;
                end else if (s1_op == OpFmin) begin
                    res_d = b_lt_a ? s1_b : s1_a;
                end else begin
                    res_d = a_lt_b ? s1_b : s1_a;
                end
            end
            default: begin
                res_d = 32'd0;
                nv_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= 32'd0;
            nv        <= 1'b0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= res_d;
                nv     <= nv_d;
            end
        end
    end

    // Set has priority so an invalid raised in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nv_acc <= 1'b0;
        end else if (out_valid & out_ready & nv) begin
            nv_acc <= 1'b1;
        end else if (nv_clr) begin
            nv_acc <= 1'b0;
        end
    end

endmodule
